// File: rtl/sd_lese_pkg.sv
// Shared constants for the SD word-read arbiter: FSM state encoding,
// the default transaction timeout and an index-width helper.
package sd_lese_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] ANFRAGE      = 2'd1;
    localparam logic [1:0] WARTE_BUSY   = 2'd2;
    localparam logic [1:0] WARTE_FERTIG = 2'd3;

    localparam int TIMEOUT_ZYKLEN_DEFAULT = 1000000;

    // Bits needed to hold a requester index; at least one bit so that a
    // single-requester build still has a legal vector.
    function automatic int idx_breite(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_rr_auswahl.sv
// Purely combinational round-robin pick: the first requesting index
// strictly after letzter_i, wrapping from ANZAHL-1 back to 0.
module sd_rr_auswahl
    import sd_lese_pkg::*;
#(
    parameter  int ANZAHL = 2,
    localparam int IW     = idx_breite(ANZAHL)
) (
    input  logic [ANZAHL-1:0] req_i,
    input  logic [IW-1:0]     letzter_i,
    output logic [IW-1:0]     grant_o,
    output logic              any_req_o
);

    logic [2*ANZAHL-1:0] doppelt;
    logic [2*ANZAHL-1:0] rotiert;
    logic [IW:0]         schieb;

    // Rotate the request vector so bit 0 is the requester right after
    // letzter_i, then take the lowest set bit and map it back.
    always_comb begin
        int g;
        doppelt   = {req_i, req_i};
        schieb    = {1'b0, letzter_i} + (IW+1)'(1);
        rotiert   = doppelt >> schieb;
        grant_o   = '0;
        any_req_o = 1'b0;
        g         = 0;
        for (int j = ANZAHL - 1; j >= 0; j--) begin
            if (rotiert[j]) begin
                g = int'(letzter_i) + 1 + j;
                if (g >= ANZAHL) g = g - ANZAHL;
                if (g >= ANZAHL) g = g - ANZAHL;
                grant_o   = IW'(g);
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_lese_arbiter.sv
// Round-robin arbiter sharing the SD-card word reader among ANZAHL
// requesters. Optional single-entry read cache: SD_LESE_CACHE_EN.
//
// Handshakes:
//   requester side - req_Lesen[i] is a level held with a stable address
//   until that requester sees req_Fertig[i] (req_Daten valid in the same
//   cycle) or req_Fehler[i]; each is a single-cycle pulse, at most one
//   bit of either vector is ever high.
//   reader side - sd_Lesen is a one-cycle strobe with sd_Adresse stable;
//   the word is taken only after sd_Busy has been seen high and then
//   sd_Busy==0 && sd_Fertig==1, because sd_Fertig may stay high from the
//   previous transfer.
module sd_lese_arbiter
    import sd_lese_pkg::*;
#(
    parameter int ANZAHL         = 2,
    parameter int TIMEOUT_ZYKLEN = TIMEOUT_ZYKLEN_DEFAULT
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [ANZAHL-1:0]    req_Lesen,
    input  logic [32*ANZAHL-1:0] req_Adresse,
    output logic [31:0]          req_Daten,
    output logic [ANZAHL-1:0]    req_Fertig,
    output logic [ANZAHL-1:0]    req_Fehler,
    output logic [31:0]          sd_Adresse,
    output logic                 sd_Lesen,
    input  logic [31:0]          sd_Daten,
    input  logic                 sd_Fertig,
    input  logic                 sd_Busy,
    output logic [1:0]           dbg_zustand_o
);

    localparam int            IW        = idx_breite(ANZAHL);
    localparam int            CW        = $clog2(TIMEOUT_ZYKLEN) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_ZYKLEN - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [1:0]        zustand_q, zustand_d;
    logic [IW-1:0]     letzter_q, letzter_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [31:0]       adresse_q, adresse_d;
    logic [31:0]       daten_q, daten_d;
    logic [ANZAHL-1:0] fertig_q, fertig_d;
    logic [ANZAHL-1:0] fehler_q, fehler_d;

    logic [IW-1:0]     rr_grant;
    logic              rr_any;
    logic [31:0]       kandidat_adr;
    logic              puls_aktiv;
    logic              abschluss;
    logic              zeitueberlauf;
    logic              treffer;
    logic [31:0]       treffer_daten;

    function automatic logic [ANZAHL-1:0] onehot(input logic [IW-1:0] g);
        logic [ANZAHL-1:0] v;
        v = '0;
        for (int i = 0; i < ANZAHL; i++) begin
            if (g == IW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    sd_rr_auswahl #(
        .ANZAHL (ANZAHL)
    ) u_rr (
        .req_i     (req_Lesen),
        .letzter_i (letzter_q),
        .grant_o   (rr_grant),
        .any_req_o (rr_any)
    );

    // Address of the requester that would win arbitration this cycle.
    always_comb begin
        kandidat_adr = '0;
        for (int i = 0; i < ANZAHL; i++) begin
            if (rr_grant == IW'(i)) kandidat_adr = req_Adresse[32*i +: 32];
        end
    end

    // While a completion/error pulse is on the wire the requester has not
    // yet dropped its level, so arbitration waits one cycle.
    assign puls_aktiv    = (|fertig_q) | (|fehler_q);
    assign abschluss     = (zustand_q == WARTE_FERTIG) && !sd_Busy && sd_Fertig;
    assign cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign zeitueberlauf = (zustand_q != IDLE) && !abschluss && (cnt_inc >= CNT_LIMIT);

`ifdef SD_LESE_CACHE_EN
    logic [31:0] cache_adr_q;
    logic [31:0] cache_daten_q;
    logic        cache_gueltig_q;

    // Remember the last good word; a timeout or reset invalidates it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cache_adr_q     <= '0;
            cache_daten_q   <= '0;
            cache_gueltig_q <= 1'b0;
        end else if (zeitueberlauf) begin
            cache_gueltig_q <= 1'b0;
        end else if (abschluss) begin
            cache_adr_q     <= adresse_q;
            cache_daten_q   <= sd_Daten;
            cache_gueltig_q <= 1'b1;
        end
    end

    assign treffer       = cache_gueltig_q && (cache_adr_q == kandidat_adr);
    assign treffer_daten = cache_daten_q;
`else
    assign treffer       = 1'b0;
    assign treffer_daten = '0;
`endif

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand_q <= IDLE;
            letzter_q <= IW'(ANZAHL - 1);
            grant_q   <= '0;
            cnt_q     <= '0;
            adresse_q <= '0;
            daten_q   <= '0;
            fertig_q  <= '0;
            fehler_q  <= '0;
        end else begin
            zustand_q <= zustand_d;
            letzter_q <= letzter_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            adresse_q <= adresse_d;
            daten_q   <= daten_d;
            fertig_q  <= fertig_d;
            fehler_q  <= fehler_d;
        end
    end

    // Next-state logic: grant, reader handshake sequencing and timeout.
    always_comb begin
        zustand_d = zustand_q;
        letzter_d = letzter_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        adresse_d = adresse_q;
        daten_d   = daten_q;
        fertig_d  = '0;
        fehler_d  = '0;

        if (zustand_q != IDLE) cnt_d = cnt_inc;

        case (zustand_q)
            IDLE: begin
                if (rr_any && !puls_aktiv) begin
                    if (treffer) begin
                        // Cache hit: answer directly, reader untouched.
                        letzter_d = rr_grant;
                        daten_d   = treffer_daten;
                        fertig_d  = onehot(rr_grant);
                    end else if (!sd_Busy) begin
                        grant_d   = rr_grant;
                        letzter_d = rr_grant;
                        adresse_d = kandidat_adr;
                        cnt_d     = '0;
                        zustand_d = ANFRAGE;
                    end
                end
            end
            ANFRAGE:      zustand_d = WARTE_BUSY;
            WARTE_BUSY:   if (sd_Busy) zustand_d = WARTE_FERTIG;
            WARTE_FERTIG: begin
                if (abschluss) begin
                    daten_d   = sd_Daten;
                    fertig_d  = onehot(grant_q);
                    zustand_d = IDLE;
                end
            end
            default:      zustand_d = IDLE;
        endcase

        if (zeitueberlauf) begin
            fehler_d  = onehot(grant_q);
            zustand_d = IDLE;
        end
    end

    // Outputs: the strobe is a pure function of state, the rest registered.
    always_comb begin
        sd_Lesen      = (zustand_q == ANFRAGE);
        sd_Adresse    = adresse_q;
        req_Daten     = daten_q;
        req_Fertig    = fertig_q;
        req_Fehler    = fehler_q;
        dbg_zustand_o = zustand_q;
    end

endmodule
